// File: rtl/ps2_scan_sequencer.sv
// ps2_scan_sequencer
//   Gates the PS/2 receiver and folds its raw byte stream into key events.
//   The byte sequences handled are: plain code, E0 code, F0 code and E0 F0 code.
//   Each event holds the make/break flag, the extended flag and the scan code.
//   Events are queued in a small show-ahead FIFO that the host pops.
//   A watchdog abandons a partial sequence when no byte has arrived for
//   TIMEOUT_CYC cycles.
//
// Ports
//   clk, reset       system clock; synchronous active-high reset
//   enable           accept keyboard traffic; rx_en is its registered copy
//   rx_done_tick     one-cycle strobe: dout holds a new received byte
//   dout             received scan byte
//   ev_rd            pop the head event (ignored while the FIFO is empty)
//   ev_valid         FIFO not empty
//   ev_code/ev_break/ev_ext   head event fields (show-ahead)
//   ev_count         number of stored events
//   overflow         sticky flag: an event was dropped because the FIFO was full
//   clr_ovf          clears overflow (a simultaneous drop wins)
module ps2_scan_sequencer #(
    parameter int FIFO_AW     = 2,
    parameter int TIMEOUT_CYC = 200000,
    parameter int TO_W        = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             rx_done_tick,
    input  logic [7:0]       dout,
    output logic             rx_en,
    input  logic             ev_rd,
    output logic             ev_valid,
    output logic [7:0]       ev_code,
    output logic             ev_break,
    output logic             ev_ext,
    output logic [FIFO_AW:0] ev_count,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } event_t;

    state_t               state;
    logic [TO_W-1:0]      to_cnt;
    event_t               mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     count;

    logic   consume;
    logic   is_err;
    logic   is_e0;
    logic   is_f0;
    logic   push_req;
    event_t push_ev;
    logic   full;
    logic   empty;
    logic   pop;
    logic   push;
    logic   drop;
    logic   timed_out;

    assign consume   = rx_done_tick && enable;
    assign is_err    = (dout == 8'h00) || (dout == 8'hFF);
    assign is_e0     = (dout == 8'hE0);
    assign is_f0     = (dout == 8'hF0);
    assign timed_out = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Event decode: a non-prefix, non-error byte completes a sequence, and the
    // current state supplies the prefix flags.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned and infers a latch.
        push_req = 1'b0;
        push_ev  = '0;
        if (consume && !is_err && !is_e0 && !is_f0) begin
            push_req     = 1'b1;
            push_ev.code = dout;
            push_ev.ext  = (state == S_E0) || (state == S_E0F0);
            push_ev.brk  = (state == S_F0) || (state == S_E0F0);
        end
    end

    assign full  = (count == (FIFO_AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign pop   = ev_rd && !empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO
    // still succeeds when the head is read at the same time.
    assign push  = push_req && (!full || pop);
    assign drop  = push_req && full && !pop;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before the clock edge.
        if (reset) begin
            rx_en    <= 1'b0;
            state    <= S_IDLE;
            to_cnt   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            // NOTE: the storage is reset as well because the head is read
            // straight from it, and the head fields must show zero after reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rx_en <= enable;

            // Sequence tracker and watchdog
            if (!enable) begin
                state  <= S_IDLE;
                to_cnt <= '0;
            end else if (consume) begin
                to_cnt <= '0;
                if (is_err) begin
                    state <= S_IDLE;
                end else begin
                    case (state)
                        S_IDLE:  state <= is_e0 ? S_E0 : (is_f0 ? S_F0 : S_IDLE);
                        S_E0:    state <= is_f0 ? S_E0F0 : (is_e0 ? S_E0 : S_IDLE);
                        S_F0:    state <= is_e0 ? S_E0F0 : (is_f0 ? S_F0 : S_IDLE);
                        S_E0F0:  state <= (is_e0 || is_f0) ? S_E0F0 : S_IDLE;
                        default: state <= S_IDLE;
                    endcase
                end
            end else if (state == S_IDLE) begin
                to_cnt <= '0;
            end else if (timed_out) begin
                state  <= S_IDLE;
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            // Event FIFO
            if (push) begin
                mem[wr_ptr] <= push_ev;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign ev_valid = !empty;
    assign ev_count = count;
    assign ev_code  = mem[rd_ptr].code;
    assign ev_break = mem[rd_ptr].brk;
    assign ev_ext   = mem[rd_ptr].ext;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// tb_ps2_scan_sequencer
//   Self-checking bench for ps2_scan_sequencer.
//   Each expected event is queued when the completing byte is driven.
//   The event is popped and compared when the DUT presents it at the FIFO head.
//   The watchdog is shortened so that the silence case stays brief.
module tb_ps2_scan_sequencer;

    localparam int FIFO_AW = 2;
    localparam int TO_CYC  = 300;
    localparam int TO_W    = 9;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             rx_done_tick;
    logic [7:0]       dout;
    logic             rx_en;
    logic             ev_rd;
    logic             ev_valid;
    logic [7:0]       ev_code;
    logic             ev_break;
    logic             ev_ext;
    logic [FIFO_AW:0] ev_count;
    logic             overflow;
    logic             clr_ovf;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb [$];   // {ext, brk, code}

    always #5 clk = ~clk;

    ps2_scan_sequencer #(
        .FIFO_AW    (FIFO_AW),
        .TIMEOUT_CYC(TO_CYC),
        .TO_W       (TO_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .rx_done_tick(rx_done_tick),
        .dout        (dout),
        .rx_en       (rx_en),
        .ev_rd       (ev_rd),
        .ev_valid    (ev_valid),
        .ev_code     (ev_code),
        .ev_break    (ev_break),
        .ev_ext      (ev_ext),
        .ev_count    (ev_count),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void expect_ev(input logic ext, input logic brk, input logic [7:0] code);
        sb.push_back({ext, brk, code});
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one received byte for a single cycle; returns on the negedge
    // just after the consuming clock edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        dout         = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    // Wait (bounded) for a head event, compare it with the scoreboard, then pop it.
    task automatic pop_check(input string tag);
        int n;
        logic [9:0] exp;
        n = 0;
        while (!ev_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        if (ev_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected event got=%0h", tag, {ev_ext, ev_break, ev_code});
            end else begin
                exp = sb.pop_front();
                check(tag, 32'({ev_ext, ev_break, ev_code}), 32'(exp));
            end
            ev_rd = 1'b1;
            @(negedge clk);
            ev_rd = 1'b0;
        end
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        rx_done_tick = 1'b0;
        dout         = 8'h00;
        ev_rd        = 1'b0;
        clr_ovf      = 1'b0;

        // T1: reset values and the one-cycle lag of rx_en
        idle(10);
        reset = 1'b0;
        check("rst_rx_en",    32'(rx_en),    32'd0);
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_ev_code",  32'(ev_code),  32'h00);
        check("rst_ev_break", 32'(ev_break), 32'd0);
        check("rst_ev_ext",   32'(ev_ext),   32'd0);
        check("rst_ev_count", 32'(ev_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        enable = 1'b1;
        check("rx_en_lag0", 32'(rx_en), 32'd0);
        @(negedge clk);
        check("rx_en_lag1", 32'(rx_en), 32'd1);

        // T2: make then break of 2B; push is visible the cycle after the byte
        send(8'h2B); expect_ev(1'b0, 1'b0, 8'h2B);
        check("t2_valid_next", 32'(ev_valid), 32'd1);
        check("t2_count1",     32'(ev_count), 32'd1);
        idle(50);
        send(8'hF0);
        idle(50);
        send(8'h2B); expect_ev(1'b0, 1'b1, 8'h2B);
        check("t2_count2", 32'(ev_count), 32'd2);
        pop_check("t2_make");
        pop_check("t2_break");
        check("t2_empty", 32'(ev_count), 32'd0);

        // T3: extended make and break
        send(8'hE0);
        check("t3_prefix_only", 32'(ev_count), 32'd0);
        send(8'h75); expect_ev(1'b1, 1'b0, 8'h75);
        send(8'hE0);
        send(8'hF0);
        check("t3_prefix2_only", 32'(ev_count), 32'd1);
        send(8'h75); expect_ev(1'b1, 1'b1, 8'h75);
        pop_check("t3_ext_make");
        pop_check("t3_ext_break");

        // T4: a stale F0 is dropped after the watchdog; a timely one is applied
        send(8'hF0);
        idle(TO_CYC + 10);
        send(8'h1C); expect_ev(1'b0, 1'b0, 8'h1C);
        check("t4_count", 32'(ev_count), 32'd1);
        pop_check("t4_stale");
        send(8'hF0);
        idle(TO_CYC - 20);
        send(8'h2C); expect_ev(1'b0, 1'b1, 8'h2C);
        pop_check("t4_in_time");

        // T5: overflow on the fifth event, ordering of the kept four, clear
        send(8'h15); expect_ev(1'b0, 1'b0, 8'h15);
        send(8'h1D); expect_ev(1'b0, 1'b0, 8'h1D);
        send(8'h24); expect_ev(1'b0, 1'b0, 8'h24);
        send(8'h2D); expect_ev(1'b0, 1'b0, 8'h2D);
        check("t5_ovf_before", 32'(overflow), 32'd0);
        send(8'h2C);
        check("t5_count_full", 32'(ev_count), 32'd4);
        check("t5_overflow",   32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) pop_check($sformatf("t5_pop%0d", i));
        check("t5_ovf_sticky", 32'(overflow), 32'd1);
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        check("t5_ovf_clr", 32'(overflow), 32'd0);

        // T6: push and pop in the same cycle while full
        send(8'h11); expect_ev(1'b0, 1'b0, 8'h11);
        send(8'h12); expect_ev(1'b0, 1'b0, 8'h12);
        send(8'h13); expect_ev(1'b0, 1'b0, 8'h13);
        send(8'h14); expect_ev(1'b0, 1'b0, 8'h14);
        @(negedge clk);
        check("t6_head", 32'({ev_ext, ev_break, ev_code}), 32'(sb.pop_front()));
        dout = 8'h3C; rx_done_tick = 1'b1; ev_rd = 1'b1;
        expect_ev(1'b0, 1'b0, 8'h3C);
        @(negedge clk);
        rx_done_tick = 1'b0; ev_rd = 1'b0;
        check("t6_count", 32'(ev_count), 32'd4);
        check("t6_no_ovf", 32'(overflow), 32'd0);
        // Drop and clr_ovf together: the drop wins
        @(negedge clk);
        dout = 8'h55; rx_done_tick = 1'b1; clr_ovf = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0; clr_ovf = 1'b0;
        check("t6_set_wins", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) pop_check($sformatf("t6_pop%0d", i));
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        // Pop request while empty alongside a push: the push still lands
        @(negedge clk);
        dout = 8'h66; rx_done_tick = 1'b1; ev_rd = 1'b1;
        expect_ev(1'b0, 1'b0, 8'h66);
        @(negedge clk);
        rx_done_tick = 1'b0; ev_rd = 1'b0;
        check("t6_empty_pushpop", 32'(ev_count), 32'd1);
        pop_check("t6_66");
        // Error byte mid-sequence aborts the prefix
        send(8'hE0);
        send(8'hFF);
        send(8'h29); expect_ev(1'b0, 1'b0, 8'h29);
        pop_check("t6_err_abort");

        // enable=0 drops the partial sequence and ignores ticks
        send(8'hE0);
        @(negedge clk); enable = 1'b0;
        idle(2);
        check("dis_rx_en", 32'(rx_en), 32'd0);
        send(8'h29);
        check("dis_ignored", 32'(ev_count), 32'd0);
        enable = 1'b1;
        idle(2);
        send(8'h29); expect_ev(1'b0, 1'b0, 8'h29);
        pop_check("dis_prefix_gone");

        // Reset mid-sequence discards queued events and the partial sequence
        send(8'h1C);
        send(8'hF0);
        @(negedge clk); reset = 1'b1;
        idle(2);
        reset = 1'b0;
        sb.delete();
        check("mrst_count", 32'(ev_count), 32'd0);
        check("mrst_valid", 32'(ev_valid), 32'd0);
        check("mrst_rx_en", 32'(rx_en),    32'd0);
        @(negedge clk);
        send(8'h1C); expect_ev(1'b0, 1'b0, 8'h1C);
        pop_check("mrst_make");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
